sar_search8: RTL and testbench
==============================

# sar_search8

Successive-approximation search engine that drives the probe operand of an 8-bit cascadable magnitude comparator (`comparator8`) and consumes its `lt/eq/gt` result. It is the initiator side of the comparator interface: given an unknown target on the comparator's `A` input, it recovers the target value by binary search, at most one trial per clock. It also drives the comparator's cascade inputs with the standalone-stage constants.

## Interface
- `WIDTH`, 8, operand width; this revision supports 8 only.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a search; sampled only in IDLE.
- `cmp_lt`  in  1  comparator `lt` (target < probe).
- `cmp_eq`  in  1  comparator `eq` (target == probe).
- `cmp_gt`  in  1  comparator `gt` (target > probe).
- `probe`  out  8  value driven to comparator `B`.
- `casc_l`, `casc_e`, `casc_g`  out  1 each  cascade inputs to the comparator; constant 0/1/0.
- `busy`  out  1  high in TRY.
- `done`  out  1  one-cycle pulse at search end.
- `result`  out  8  recovered target; held until the next `start`.
- `found`  out  1  result valid; held with `result`.
- `err`  out  1  inconsistent comparator response; held with `result`.

## Operation
- Comparator path is combinational: flags are sampled in the same cycle `probe` is presented.
- States: IDLE, TRY, DONE.
- IDLE: `probe`=0, `busy`=0. `start`=1 -> TRY; `probe`<=8'h80, bit index `k`<=7; `result`, `found`, `err` cleared.
- TRY, per cycle, flags are evaluated in priority order:
  - Flags not one-hot (none set, or more than one set) -> DONE; `err`=1, `found`=0, `result`=`probe`.
  - `cmp_eq` -> DONE; `result`=`probe`, `found`=1 (early exit).
  - `cmp_lt` -> clear bit `k` of `probe`.
  - `cmp_gt` -> keep bit `k`.
  - If `k`>0, set bit `k-1` and decrement `k`; stay in TRY.
  - If `k`==0 and `cmp_lt` -> DONE; `result`=`probe` with bit 0 cleared, `found`=1.
  - If `k`==0 and `cmp_gt` -> DONE; `err`=1, `found`=0. This case is impossible under a consistent comparator.
- DONE: `done`=1 for exactly this cycle, `probe` returns to 0, then -> IDLE unconditionally.
- `start` in TRY or DONE is ignored and is not queued.
- `casc_l`=0, `casc_e`=1, `casc_g`=0 at all times, including during reset.

## Timing
- Reset values: `probe`=0, `busy`=0, `done`=0, `result`=0, `found`=0, `err`=0; state IDLE.
- `rst_n` low at any edge, including mid-search, forces the reset values at that edge; the search is abandoned and no `done` pulse is produced.
- `start` sampled at edge n:
  - TRY from n+1, with `probe`=8'h80 visible after edge n.
  - Trial i uses the probe visible between edges n+i-1 and n+i.
- Worst case is 8 trials: `done` is high in the cycle after edge n+8. With `eq` on trial j, `done` is high after edge n+j.
- `result`, `found`, and `err` are valid from the `done` cycle and stable until the edge that accepts the next `start`.
- Back-to-back searches: `start` asserted during the `done` cycle is ignored. The earliest accepted `start` is sampled in IDLE, one cycle later.

## Structure
- Package `sar_pkg` holds:
  - state enum `sar_state_t` {IDLE, TRY, DONE};
  - `SAR_WIDTH`=8;
  - cascade constants `CASC_L`=0, `CASC_E`=1, `CASC_G`=0;
  - probe reset value `PROBE_RST`=8'h80.
- Single module; no sub-module. The 3-bit `k` counter and the bit set/clear logic are inline.
- The comparator itself is not instantiated here; the top level or bench connects `comparator8` with `A`=target, `B`=`probe`, and `l/e/g`=`casc_*`.

## Test plan
- Target 8'h80, `start` at edge 0 -> `eq` on trial 1; `done` after edge 1; `result`=8'h80, `found`=1, `busy` high one cycle.
- Target 8'h00 -> 8 trials, probes 80,40,20,10,08,04,02,01; `done` after edge 8; `result`=8'h00, `found`=1.
- Target 8'hFF -> probes 80,C0,E0,F0,F8,FC,FE,FF; `eq` on trial 8; `result`=8'hFF, `found`=1.
- Targets 8'h01, 8'h02, 8'h5A -> `result` equals target, `found`=1, `err`=0, `casc_*` constant 0/1/0 throughout.
- Flag faults:
  - Forcing `cmp_lt`=`cmp_gt`=1 on trial 3 -> `done` after edge 3, `err`=1, `found`=0.
  - Forcing all flags 0 -> same error response.
- Control robustness:
  - `start` pulsed during TRY -> no restart.
  - `rst_n` low at trial 4 -> all outputs reset at that edge, no `done`.
  - A fresh `start` after reset completes normally.

Source files
------------

// File: rtl/sar_pkg.sv
// sar_pkg
//   Shared definitions for the successive-approximation search engine:
//   FSM state encoding, operand width, comparator cascade constants and
//   the first probe value of every search.
package sar_pkg;

    localparam int SAR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } sar_state_t;

    // A standalone comparator stage sees "equal so far" from its cascade inputs.
    localparam logic CASC_L = 1'b0;
    localparam logic CASC_E = 1'b1;
    localparam logic CASC_G = 1'b0;

    // First trial tests the MSB alone: half of the code space.
    localparam logic [SAR_WIDTH-1:0] PROBE_RST = 8'h80;

endpackage : sar_pkg

// File: rtl/sar_search8.sv
// sar_search8
//   Binary-search engine driving the probe operand (B) of an external
//   8-bit magnitude comparator whose A input carries an unknown target.
//   One trial per clock, MSB first; early exit when the comparator
//   reports equality. Inconsistent comparator flags end the search with
//   err set.
//
// Ports
//   clk                      rising-edge clock
//   rst_n                    synchronous active-low reset
//   start                    begin a search (honoured only in IDLE)
//   cmp_lt/cmp_eq/cmp_gt     comparator result for the current probe
//   probe[7:0]               value driven to comparator B
//   casc_l/casc_e/casc_g     comparator cascade inputs, constant 0/1/0
//   busy                     high while trials are running
//   done                     one-cycle pulse at search end
//   result[7:0]              recovered target, held until next start
//   found                    result valid, held with result
//   err                      inconsistent comparator response, held
module sar_search8
    import sar_pkg::*;
#(
    parameter int WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cmp_lt,
    input  logic             cmp_eq,
    input  logic             cmp_gt,
    output logic [WIDTH-1:0] probe,
    output logic             casc_l,
    output logic             casc_e,
    output logic             casc_g,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             found,
    output logic             err
);

    sar_state_t       state;
    logic [2:0]       k;            // bit currently under trial
    logic             flags_ok;     // exactly one of lt/eq/gt asserted
    logic [WIDTH-1:0] next_probe;   // bit k resolved, bit k-1 set for next trial

    // Cascade inputs are wired constants so they hold through reset too.
    assign casc_l = CASC_L;
    assign casc_e = CASC_E;
    assign casc_g = CASC_G;

    assign flags_ok = $onehot({cmp_lt, cmp_eq, cmp_gt});

    // NOTE: every variable written here gets a default first, otherwise
    // the paths that skip an assignment would infer a latch.
    always_comb begin
        next_probe = probe;
        if (cmp_lt) begin
            next_probe[k] = 1'b0;
        end
        if (k != 3'd0) begin
            next_probe[k - 3'd1] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            probe  <= '0;
            k      <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            found  <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= TRY;
                        probe  <= PROBE_RST;
                        k      <= 3'd7;
                        busy   <= 1'b1;
                        result <= '0;
                        found  <= 1'b0;
                        err    <= 1'b0;
                    end
                end

                TRY: begin
                    if (!flags_ok) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        probe  <= '0;
                        result <= probe;
                        found  <= 1'b0;
                        err    <= 1'b1;
                    end else if (cmp_eq) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        probe  <= '0;
                        result <= probe;
                        found  <= 1'b1;
                    end else if (k != 3'd0) begin
                        probe <= next_probe;
                        k     <= k - 3'd1;
                    end else begin
                        // Last bit: "less than" pins the target to probe with
                        // bit 0 clear; "greater than" cannot happen because
                        // the probe already has every lower bit set.
                        state  <= DONE;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        probe  <= '0;
                        result <= next_probe;
                        found  <= cmp_lt;
                        err    <= cmp_gt;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    probe <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : sar_search8

// File: tb/tb_sar_search8.sv
// tb_sar_search8
//   Directed bench for sar_search8. A behavioural comparator model answers
//   the DUT's probes for a chosen target; a fault injector can override the
//   flags on a chosen trial. Outputs are sampled 1 ns after each rising edge.
module tb_sar_search8;
    import sar_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       cmp_lt, cmp_eq, cmp_gt;
    logic [7:0] probe;
    logic       casc_l, casc_e, casc_g;
    logic       busy, done, found, err;
    logic [7:0] result;

    logic [7:0] target;
    int         trial;          // trial number currently presented, 0 = none
    int         fault_trial;    // 0 = no fault injection
    int         fault_mode;     // 1 = lt and gt both set, 2 = no flag set
    logic [7:0] probe_log [8];

    int checks;
    int errors;
    int casc_bad;

    sar_search8 #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmp_lt (cmp_lt),
        .cmp_eq (cmp_eq),
        .cmp_gt (cmp_gt),
        .probe  (probe),
        .casc_l (casc_l),
        .casc_e (casc_e),
        .casc_g (casc_g),
        .busy   (busy),
        .done   (done),
        .result (result),
        .found  (found),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparator model with optional fault override.
    always_comb begin
        cmp_lt = (target < probe);
        cmp_eq = (target == probe);
        cmp_gt = (target > probe);
        if (fault_trial != 0 && trial == fault_trial) begin
            if (fault_mode == 1) begin
                cmp_lt = 1'b1;
                cmp_eq = 1'b0;
                cmp_gt = 1'b1;
            end else begin
                cmp_lt = 1'b0;
                cmp_eq = 1'b0;
                cmp_gt = 1'b0;
            end
        end
    end

    // Cascade outputs must read 0/1/0 on every falling edge, reset included.
    always @(negedge clk) begin
        if ({casc_l, casc_e, casc_g} !== 3'b010) casc_bad <= casc_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a search and follow it to its done pulse. start_again_trial
    // pulses start during that trial to confirm it is ignored.
    task automatic do_search(input logic [7:0] tgt, input int exp_trials,
                             input logic [7:0] exp_res, input logic exp_found,
                             input logic exp_err, input int start_again_trial,
                             input string tag);
        int  n;
        bit  seen;
        target = tgt;
        start  = 1'b1;
        step();
        start = 1'b0;
        trial = 1;
        check({tag, " first probe"}, 32'(probe), 32'h80);
        check({tag, " busy"}, 32'(busy), 32'd1);
        seen = 1'b0;
        for (n = 1; n <= 12; n++) begin
            if (n <= 8) probe_log[n-1] = probe;
            start = (n == start_again_trial);
            step();
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            trial++;
        end
        trial = 0;
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " trials"}, 32'(n), 32'(exp_trials));
        check({tag, " result"}, 32'(result), 32'(exp_res));
        check({tag, " found"}, 32'(found), 32'(exp_found));
        check({tag, " err"}, 32'(err), 32'(exp_err));
        check({tag, " busy in done"}, 32'(busy), 32'd0);
        step();
        check({tag, " done pulse width"}, 32'(done), 32'd0);
        check({tag, " idle probe"}, 32'(probe), 32'd0);
        check({tag, " result held"}, 32'(result), 32'(exp_res));
    endtask

    initial begin
        int  n;
        bit  seen;
        logic [7:0] exp_seq;
        checks      = 0;
        errors      = 0;
        casc_bad    = 0;
        trial       = 0;
        fault_trial = 0;
        fault_mode  = 0;
        target      = 8'h00;
        start       = 1'b0;
        rst_n       = 1'b0;
        step();
        step();
        check("reset probe", 32'(probe), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset found", 32'(found), 32'd0);
        check("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle busy", 32'(busy), 32'd0);

        // Early exit on first trial.
        do_search(8'h80, 1, 8'h80, 1'b1, 1'b0, 0, "t80");

        // Target 0: all eight trials, final decision on bit 0 "less than".
        do_search(8'h00, 8, 8'h00, 1'b1, 1'b0, 0, "t00");
        exp_seq = 8'h80;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t00 probe %0d", i + 1), 32'(probe_log[i]), 32'(exp_seq));
            exp_seq = exp_seq >> 1;
        end

        // Target FF with a start pulse during trial 3 that must be ignored.
        do_search(8'hFF, 8, 8'hFF, 1'b1, 1'b0, 3, "tFF");
        check("tFF probe 2", 32'(probe_log[1]), 32'hC0);
        check("tFF probe 4", 32'(probe_log[3]), 32'hF0);
        check("tFF probe 8", 32'(probe_log[7]), 32'hFF);

        do_search(8'h01, 8, 8'h01, 1'b1, 1'b0, 0, "t01");
        do_search(8'h02, 7, 8'h02, 1'b1, 1'b0, 0, "t02");
        do_search(8'h5A, 7, 8'h5A, 1'b1, 1'b0, 0, "t5A");
        check("t5A probe 3", 32'(probe_log[2]), 32'h60);
        check("t5A probe 6", 32'(probe_log[5]), 32'h5C);

        // Flag faults.
        fault_mode  = 1;
        fault_trial = 3;
        do_search(8'h5A, 3, 8'h60, 1'b0, 1'b1, 0, "lt_gt fault");
        fault_mode  = 2;
        fault_trial = 1;
        do_search(8'h33, 1, 8'h80, 1'b0, 1'b1, 0, "no flag fault");
        fault_trial = 0;
        fault_mode  = 0;

        // Reset during trial 4 abandons the search without a done pulse.
        target = 8'h33;
        start  = 1'b1;
        step();
        start = 1'b0;
        trial = 1;
        step();
        trial = 2;
        step();
        trial = 3;
        step();
        trial = 4;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        trial = 0;
        check("mid reset probe", 32'(probe), 32'd0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset found", 32'(found), 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done) seen = 1'b1;
        end
        check("no done after reset", 32'(seen), 32'd0);

        // Fresh search after reset, with start held into the done cycle.
        // 0x33: probes 80,40,20,30,38,34,32,33 -> eq on trial 8.
        target = 8'h33;
        start  = 1'b1;
        step();
        start = 1'b0;
        seen  = 1'b0;
        for (n = 1; n <= 12; n++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("post-reset done", 32'(seen), 32'd1);
        check("post-reset trials", 32'(n), 32'd8);
        check("post-reset result", 32'(result), 32'h33);
        check("post-reset found", 32'(found), 32'd1);
        start = 1'b1;
        step();
        check("start in done ignored", 32'(busy), 32'd0);
        check("start in done probe", 32'(probe), 32'd0);
        step();
        start = 1'b0;
        check("start in idle accepted", 32'(busy), 32'd1);
        check("restart clears result", 32'(result), 32'd0);
        seen = 1'b0;
        for (n = 1; n <= 12; n++) begin
            step();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check("b2b done", 32'(seen), 32'd1);
        check("b2b result", 32'(result), 32'h33);
        step();

        check("cascade constant", 32'(casc_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sar_search8
